// File: rtl/bbpd_lf_pkg.sv
// Shared types and constants for the bang-bang PD loop filter.
package bbpd_lf_pkg;

  localparam int unsigned NDEC_DEF = 8;
  localparam int unsigned KP_DEF   = 4;
  localparam int unsigned KI_DEF   = 1;

  // Decision encoding: hold, advance (up), retard (dn).
  typedef enum logic [1:0] {
    DEC_HOLD = 2'b00,
    DEC_UP   = 2'b01,
    DEC_DN   = 2'b11
  } dec_t;

  // Symmetric saturation limit of a w-bit signed integrator (w <= 31).
  function automatic int sat_lim(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/bbpd_vote_decimator.sv
// Majority vote of up/dn pulses over NDEC-cycle windows; emits one decision per window.
module bbpd_vote_decimator
  import bbpd_lf_pkg::*;
#(
  parameter int unsigned NDEC = NDEC_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic up,
  input  logic dn,
  output dec_t decision,
  output logic decision_vld
);

  localparam int unsigned W_CNT = (NDEC > 1) ? $clog2(NDEC) : 1;
  localparam int unsigned W_VS  = $clog2(NDEC + 1) + 1;
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(NDEC - 1);

  logic [W_CNT-1:0]       dcnt;
  logic signed [W_VS-1:0] vsum;
  logic signed [W_VS-1:0] vote;
  logic signed [W_VS-1:0] vfinal;
  logic                   win_end;
  dec_t                   dec_next;

  // Current-cycle vote and the window total including it.
  always_comb begin
    vote = '0;
    if (up && !dn) begin
      vote = W_VS'(1);
    end else if (dn && !up) begin
      vote = '1;
    end
    vfinal  = vsum + vote;
    win_end = (dcnt == CNT_LAST);
    if (vfinal == '0) begin
      dec_next = DEC_HOLD;
    end else if (vfinal[W_VS-1]) begin
      dec_next = DEC_DN;
    end else begin
      dec_next = DEC_UP;
    end
  end

  // Window counter, running vote sum and registered decision with one-cycle pending flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt         <= '0;
      vsum         <= '0;
      decision     <= DEC_HOLD;
      decision_vld <= 1'b0;
    end else begin
      decision_vld <= 1'b0;
      if (!en) begin
        dcnt <= '0;
        vsum <= '0;
      end else if (win_end) begin
        dcnt         <= '0;
        vsum         <= '0;
        decision     <= dec_next;
        decision_vld <= 1'b1;
      end else begin
        dcnt <= dcnt + W_CNT'(1);
        vsum <= vfinal;
      end
    end
  end

endmodule

// File: rtl/bbpd_loop_filter.sv
// Proportional-plus-integral CDR loop filter producing a wrapping phase-interpolator code.
module bbpd_loop_filter
  import bbpd_lf_pkg::*;
#(
  parameter int unsigned NDEC  = NDEC_DEF,
  parameter int unsigned KP    = KP_DEF,
  parameter int unsigned KI    = KI_DEF,
  parameter int unsigned W_INT = 12,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned W_PC  = 7
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    frz_int,
  input  logic                    up,
  input  logic                    dn,
  output logic [W_PC-1:0]         pi_code,
  output logic                    pi_code_vld,
  output logic signed [W_INT-1:0] integ,
  output logic [1:0]              dec
);

  localparam int unsigned W_PA = W_PC + FRAC;
  localparam int unsigned W_IS = W_INT + 2;
  localparam logic signed [W_IS-1:0] LIM_P = W_IS'(sat_lim(W_INT));
  localparam logic signed [W_IS-1:0] LIM_N = -LIM_P;
  localparam logic signed [W_IS-1:0] ISTEP = W_IS'(KI);
  localparam logic [W_PA-1:0]        PSTEP = W_PA'(KP << FRAC);

  dec_t                    decision;
  logic                    decision_vld;
  logic signed [W_IS-1:0]  integ_sum;
  logic signed [W_INT-1:0] integ_new;
  logic [W_PA-1:0]         integ_pa;
  logic [W_PA-1:0]         pacc;
  logic [W_PA-1:0]         pacc_new;

  bbpd_vote_decimator #(
    .NDEC (NDEC)
  ) u_vote (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .up           (up),
    .dn           (dn),
    .decision     (decision),
    .decision_vld (decision_vld)
  );

  // Saturating integrator step and wrapping phase-accumulator step for the pending decision.
  always_comb begin
    integ_new = integ;
    if (decision == DEC_DN) begin
      integ_sum = W_IS'(integ) - ISTEP;
    end else begin
      integ_sum = W_IS'(integ) + ISTEP;
    end
    if (decision != DEC_HOLD && !frz_int) begin
      if (integ_sum > LIM_P) begin
        integ_new = W_INT'(LIM_P);
      end else if (integ_sum < LIM_N) begin
        integ_new = W_INT'(LIM_N);
      end else begin
        integ_new = W_INT'(integ_sum);
      end
    end
    integ_pa = W_PA'(integ_new);
    pacc_new = pacc + integ_pa;
    if (decision == DEC_UP) begin
      pacc_new = pacc + integ_pa + PSTEP;
    end else if (decision == DEC_DN) begin
      pacc_new = pacc + integ_pa - PSTEP;
    end
  end

  // Update stage: applies a pending decision one edge after it is made, even if en has fallen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      integ       <= '0;
      pacc        <= '0;
      dec         <= DEC_HOLD;
      pi_code_vld <= 1'b0;
    end else begin
      pi_code_vld <= decision_vld;
      if (decision_vld) begin
        integ <= integ_new;
        pacc  <= pacc_new;
        dec   <= decision;
      end
    end
  end

  assign pi_code = pacc[W_PA-1:FRAC];

endmodule

// File: tb/tb_bbpd_loop_filter.sv
// Directed bench for bbpd_loop_filter: default instance plus a narrow-integrator instance.
module tb_bbpd_loop_filter;
  import bbpd_lf_pkg::*;

  logic              clk;
  logic              rstn;
  logic              en;
  logic              frz_int;
  logic              up;
  logic              dn;
  logic [6:0]        pc_a;
  logic              vld_a;
  logic signed [11:0] integ_a;
  logic [1:0]        dec_a;
  logic [6:0]        pc_b;
  logic              vld_b;
  logic signed [3:0] integ_b;
  logic [1:0]        dec_b;

  int total = 0;
  int bad   = 0;
  bit sel_b = 1'b0;

  bbpd_loop_filter #(
    .NDEC(8), .KP(4), .KI(1), .W_INT(12), .FRAC(8), .W_PC(7)
  ) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .frz_int(frz_int), .up(up), .dn(dn),
    .pi_code(pc_a), .pi_code_vld(vld_a), .integ(integ_a), .dec(dec_a)
  );

  bbpd_loop_filter #(
    .NDEC(8), .KP(4), .KI(1), .W_INT(4), .FRAC(2), .W_PC(7)
  ) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .frz_int(frz_int), .up(up), .dn(dn),
    .pi_code(pc_b), .pi_code_vld(vld_b), .integ(integ_b), .dec(dec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset asserted mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    #2;
    chk("rst_pc_a", 32'(pc_a), 0);
    chk("rst_vld_a", 32'(vld_a), 0);
    chk("rst_integ_a", int'(integ_a), 0);
    chk("rst_dec_a", 32'(dec_a), 0);
    chk("rst_pc_b", 32'(pc_b), 0);
    chk("rst_integ_b", int'(integ_b), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // One 8-cycle window of votes; the first edge optionally shows the previous window's update.
  task automatic win(input string tag, input logic [7:0] u, input logic [7:0] d,
                     input bit chk_upd, input int e_pc, input logic [1:0] e_dec,
                     input int e_int);
    logic [31:0] o_vld;
    logic [31:0] o_pc;
    logic [31:0] o_dec;
    int          o_int;
    for (int i = 0; i < 8; i++) begin
      up = u[i];
      dn = d[i];
      tick();
      o_vld = sel_b ? 32'(vld_b) : 32'(vld_a);
      o_pc  = sel_b ? 32'(pc_b) : 32'(pc_a);
      o_dec = sel_b ? 32'(dec_b) : 32'(dec_a);
      o_int = sel_b ? int'(integ_b) : int'(integ_a);
      if (i == 0 && chk_upd) begin
        chk({tag, "_vld"}, o_vld, 1);
        chk({tag, "_pc"}, o_pc, 32'(e_pc));
        chk({tag, "_dec"}, o_dec, 32'(e_dec));
        chk({tag, "_integ"}, o_int, e_int);
      end else begin
        chk({tag, "_idle_vld"}, o_vld, 0);
      end
    end
  endtask

  initial begin
    int exp_pacc;
    int ib;
    rstn = 1'b0; en = 1'b0; frz_int = 1'b0; up = 1'b0; dn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1; en = 1'b1; up = 1'b1;
    repeat (4) tick();

    // 1: reset mid-window with up held, then idle votes for 64 cycles
    do_reset();
    up = 1'b0; dn = 1'b0; en = 1'b1; frz_int = 1'b0;
    win("t1_first", 8'h00, 8'h00, 1'b0, 0, 2'b00, 0);
    for (int n = 1; n <= 7; n++) win("t1_hold", 8'h00, 8'h00, 1'b1, 0, DEC_HOLD, 0);

    // 2: constant up, integrator frozen: +4 per decision, wraps at 32 decisions
    do_reset();
    en = 1'b1; frz_int = 1'b1;
    win("t2_first", 8'hFF, 8'h00, 1'b0, 0, 2'b00, 0);
    for (int n = 1; n <= 33; n++) win("t2_up", 8'hFF, 8'h00, 1'b1, (4 * n) % 128, DEC_UP, 0);

    // 3: tie and conflict windows
    do_reset();
    en = 1'b1; frz_int = 1'b1;
    win("t3_a", 8'hFF, 8'h00, 1'b0, 0, 2'b00, 0);
    win("t3_tie", 8'b0111_0101, 8'b1011_1010, 1'b1, 4, DEC_UP, 0);
    win("t3_both", 8'b0111_1111, 8'b1111_1111, 1'b1, 4, DEC_HOLD, 0);
    win("t3_flush", 8'h00, 8'h00, 1'b1, 0, DEC_DN, 0);

    // 4: constant dn with integrator active: pacc -= 1024 + n each decision
    do_reset();
    en = 1'b1; frz_int = 1'b0;
    exp_pacc = 0;
    win("t4_first", 8'h00, 8'hFF, 1'b0, 0, 2'b00, 0);
    for (int n = 1; n <= 10; n++) begin
      exp_pacc = (exp_pacc - 1024 - n) & 32'h7FFF;
      win("t4_dn", 8'h00, 8'hFF, 1'b1, exp_pacc >>> 8, DEC_DN, -n);
    end

    // 5: narrow integrator saturates at +7
    sel_b = 1'b1;
    do_reset();
    en = 1'b1; frz_int = 1'b0;
    exp_pacc = 0;
    win("t5_first", 8'hFF, 8'h00, 1'b0, 0, 2'b00, 0);
    for (int n = 1; n <= 20; n++) begin
      ib = (n < 7) ? n : 7;
      exp_pacc = (exp_pacc + 16 + ib) & 32'h1FF;
      win("t5_sat", 8'hFF, 8'h00, 1'b1, exp_pacc >>> 2, DEC_UP, ib);
    end
    sel_b = 1'b0;

    // 6: en drops right after the decision edge; pending update still lands
    do_reset();
    en = 1'b1; frz_int = 1'b1;
    win("t6_first", 8'hFF, 8'h00, 1'b0, 0, 2'b00, 0);
    en = 1'b0;
    tick();
    chk("t6_pend_vld", 32'(vld_a), 1);
    chk("t6_pend_pc", 32'(pc_a), 4);
    chk("t6_pend_dec", 32'(dec_a), 32'(DEC_UP));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_off_vld", 32'(vld_a), 0);
    end
    chk("t6_off_pc", 32'(pc_a), 4);
    en = 1'b1;
    win("t6_reen", 8'hFF, 8'h00, 1'b0, 0, 2'b00, 0);
    win("t6_next", 8'h00, 8'h00, 1'b1, 8, DEC_UP, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
